// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer
//   Time-multiplexed logic unit. One shared W-bit bitwise NAND cell and four
//   scratch registers (R0-R3) evaluate NOT/AND/OR/NOR/XOR/XNOR/NAND. Each
//   function is a fixed micro-sequence with one NAND evaluation per cycle.
//   The result always ends up in R0.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake; in_op, in_a, in_b are latched on accept
//   in_op               0 NOT, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NAND, 7 illegal
//   out_valid/out_ready result handshake; out_result, out_op, out_err are held
//                       stable while waiting
//   busy                sequencer not idle
//   nand_count          (NAND_SEQ_STATS_EN only) saturating count of NAND
//                       evaluations since reset
//
// Build option: define NAND_SEQ_STATS_EN to add the nand_count port.
module nand_op_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_op,
  output logic         out_err,
  output logic         busy
`ifdef NAND_SEQ_STATS_EN
  ,
  output logic [31:0]  nand_count
`endif
);

  typedef enum logic [2:0] {
    OP_NOT, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_NAND, OP_ILLEGAL
  } op_e;

  // S_ILL is a one-cycle turnaround for the illegal opcode so its result
  // appears one cycle after accept, like a one-step operation, but without
  // touching the NAND cell.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ILL, S_DONE} state_e;

  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_R0, SRC_R1, SRC_R2, SRC_R3} src_e;

  state_e       state, state_nx;
  op_e          op_q;
  logic         err_q;
  logic [2:0]   step;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] r_q [4];

  src_e         p_sel, q_sel;
  logic [1:0]   dst;
  logic         last;
  logic [W-1:0] nand_y;

  function automatic logic [W-1:0] pick(input src_e s, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] r0,
                                        input logic [W-1:0] r1, input logic [W-1:0] r2,
                                        input logic [W-1:0] r3);
    case (s)
      SRC_A:   return a;
      SRC_B:   return b;
      SRC_R0:  return r0;
      SRC_R1:  return r1;
      SRC_R2:  return r2;
      default: return r3;
    endcase
  endfunction

  // Micro-sequence decode: operand sources, destination register and
  // whether this is the final step of the current operation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    p_sel = SRC_R0;
    q_sel = SRC_R0;
    dst   = 2'd0;
    last  = 1'b1;
    case (op_q)
      OP_NAND: begin p_sel = SRC_A; q_sel = SRC_B; end
      OP_NOT:  begin p_sel = SRC_A; q_sel = SRC_A; end
      OP_AND: begin
        if (step == 3'd0) begin p_sel = SRC_A; q_sel = SRC_B; end
        last = (step == 3'd1);
      end
      OP_OR, OP_NOR: begin
        case (step)
          3'd0:    begin p_sel = SRC_A;  q_sel = SRC_A; end
          3'd1:    begin p_sel = SRC_B;  q_sel = SRC_B;  dst = 2'd1; end
          3'd2:    begin p_sel = SRC_R0; q_sel = SRC_R1; end
          default: ;  // NOR tail: R0 = nand(R0,R0)
        endcase
        last = (op_q == OP_OR) ? (step == 3'd2) : (step == 3'd3);
      end
      OP_XOR, OP_XNOR: begin
        case (step)
          3'd0:    begin p_sel = SRC_A;  q_sel = SRC_A; end
          3'd1:    begin p_sel = SRC_B;  q_sel = SRC_B;  dst = 2'd1; end
          3'd2:    begin p_sel = SRC_A;  q_sel = SRC_R1; dst = 2'd2; end
          3'd3:    begin p_sel = SRC_R0; q_sel = SRC_B;  dst = 2'd3; end
          3'd4:    begin p_sel = SRC_R2; q_sel = SRC_R3; end
          default: ;  // XNOR tail: R0 = nand(R0,R0)
        endcase
        last = (op_q == OP_XOR) ? (step == 3'd4) : (step == 3'd5);
      end
      default: ;
    endcase
  end

  // The single shared NAND cell.
  assign nand_y = ~(pick(p_sel, a_q, b_q, r_q[0], r_q[1], r_q[2], r_q[3]) &
                    pick(q_sel, a_q, b_q, r_q[0], r_q[1], r_q[2], r_q[3]));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) state_nx = (in_op == OP_ILLEGAL) ? S_ILL : S_EXEC;
      S_EXEC: if (last) state_nx = S_DONE;
      S_ILL:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= OP_NOT;
      err_q <= 1'b0;
      step  <= 3'd0;
      a_q   <= '0;
      b_q   <= '0;
      // NOTE: the scratch file is only four registers and R0 drives
      // out_result, so it is reset rather than left uninitialised.
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          op_q  <= op_e'(in_op);
          err_q <= (in_op == OP_ILLEGAL);
          step  <= 3'd0;
        end
        S_EXEC: begin
          r_q[dst] <= nand_y;
          step     <= step + 3'd1;
        end
        S_ILL:   r_q[0] <= '0;
        default: ;
      endcase
    end
  end

`ifdef NAND_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) nand_count <= '0;
    else if (state == S_EXEC && nand_count != 32'hFFFF_FFFF) nand_count <= nand_count + 32'd1;
  end
`endif

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = r_q[0];
  assign out_op     = op_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
module tb_nand_op_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [2:0]   out_op;
  logic         out_err;
  logic         busy;
`ifdef NAND_SEQ_STATS_EN
  logic [31:0]  nand_count;
`endif

  nand_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .out_err(out_err), .busy(busy)
`ifdef NAND_SEQ_STATS_EN
    , .nand_count(nand_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] func_of(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~(a & b);
      default: return '0;
    endcase
  endfunction

  function automatic int latency_of(input logic [2:0] op);
    case (op)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 3;
      3'd3: return 4;
      3'd4: return 5;
      3'd5: return 6;
      default: return 1;
    endcase
  endfunction

  logic         m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [2:0]   m_op = '0;
  int           m_left = 0;
  longint       m_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_err = 0; m_res = '0; m_op = '0; m_left = 0; m_count = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_left = latency_of(in_op); m_res = func_of(in_op, in_a, in_b);
        m_op = in_op; m_err = (in_op == 3'd7);
      end
    end else if (!m_valid) begin
      if (!m_err) m_count++;
      m_left--;
      if (m_left == 0) m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0; m_busy = 0;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cmp_in_ready", in_ready, !m_busy);
      check("cmp_busy", busy, m_busy);
      check("cmp_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("cmp_out_result", out_result, m_res);
        check("cmp_out_op", out_op, m_op);
        check("cmp_out_err", out_err, m_err);
      end
`ifdef NAND_SEQ_STATS_EN
      check("cmp_nand_count", nand_count, m_count[31:0]);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  // Issues one request, measures latency from the accept edge, optionally
  // stalls the consumer, then completes the handshake.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res,
                       input int exp_lat, input int stall);
    int guard = 0;
    int lat = 0;
    @(negedge clk);
    in_valid = 1; in_op = op; in_a = a; in_b = b; out_ready = (stall == 0);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);  // accept edge has passed
    in_valid = 0; in_a = ~a; in_b = a ^ b; in_op = 3'd6;  // must be ignored
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, out_result, exp_res);
    check({name, "_op"}, out_op, op);
    check({name, "_err"}, out_err, op == 3'd7);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_result"}, out_result, exp_res);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    check({name, "_idle_after"}, in_ready, 1);
  endtask

  initial begin
    int guard;
    logic [31:0] cnt_before;
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_result", out_result, 0);
    check("reset_out_op", out_op, 0);
    check("reset_out_err", out_err, 0);
`ifdef NAND_SEQ_STATS_EN
    check("reset_nand_count", nand_count, 0);
`endif
    cmp_en = 1;

    do_op("xor",  3'd4, 8'hF0, 8'hCC, 8'h3C, 5, 0);
    do_op("xnor", 3'd5, 8'hF0, 8'hCC, 8'hC3, 6, 0);
    do_op("nor",  3'd3, 8'h0A, 8'h50, 8'hA5, 4, 0);
    do_op("or",   3'd2, 8'h0A, 8'h50, 8'h5A, 3, 4);
    do_op("and",  3'd1, 8'hF0, 8'h3C, 8'h30, 2, 1);
    do_op("nand", 3'd6, 8'hF0, 8'h3C, 8'hCF, 1, 0);
`ifdef NAND_SEQ_STATS_EN
    cnt_before = nand_count;
`else
    cnt_before = 0;
`endif
    do_op("illegal", 3'd7, 8'hAA, 8'h55, 8'h00, 1, 0);
`ifdef NAND_SEQ_STATS_EN
    check("illegal_count_unchanged", nand_count, cnt_before);
`endif

    // Reset in the middle of an XOR, while the step counter reads 3.
    @(negedge clk);
    in_valid = 1; in_op = 3'd4; in_a = 8'hF0; in_b = 8'hCC;
    @(negedge clk);  // accept edge passed
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_result", out_result, 0);
    do_op("not", 3'd0, 8'h0F, 8'h00, 8'hF0, 1, 1);
`ifdef NAND_SEQ_STATS_EN
    check("not_count_after_rst", nand_count, 1);
`endif

    // in_valid held high across two operations.
    @(negedge clk);
    in_valid = 1; in_op = 3'd1; in_a = 8'hFF; in_b = 8'h3C; out_ready = 1;
    guard = 0;
    while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
    check("b2b_first_result", out_result, 8'h3C);
    in_op = 3'd6;  // next request queued while DONE; ignored until idle
    @(negedge clk);  // handshake edge passed
    check("b2b_idle_gap", in_ready, 1);
    @(negedge clk);  // second accept edge passed
    check("b2b_second_accept", busy, 1);
    in_valid = 0;
    @(negedge clk);
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_result", out_result, 8'hC3);
    @(negedge clk);
    check("b2b_final_idle", in_ready, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
